muldiv_issue_arbiter: RTL and testbench
=======================================

Name: muldiv_issue_arbiter

Overview:
- Parametrised LANES-wide issue steering block in the execute stage, between the ID/EX register and the ALUs plus the shared multiply/divide unit.
- Nulls squashed or forward-stalled lane ops.
- Routes M-extension ops (op >= MOP_BASE) to the single M-unit in program order through a DEPTH-entry deferral queue with a valid/ready handshake.
- Back-pressures issue when the queue cannot absorb a bundle.

Parameters:
- LANES, 2, number of issue lanes; lane 0 is oldest.
- DATA_WIDTH, 32, operand width.
- OP_WIDTH, 5, ALU op code width.
- MOP_BASE, 16, lowest op code treated as an M-op.
- DEPTH, 2, deferral queue entries; must be >= 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  LANES  lane holds a real instruction.
- in_op  in  LANES*OP_WIDTH  lane ops; lane i occupies bits [i*OP_WIDTH +: OP_WIDTH].
- in_s1, in_s2  in  LANES*DATA_WIDTH  lane operands, packed the same way.
- lane_block  in  LANES  lane i is a load/store or branch; squashes every lane j>i.
- fwd_stall  in  1  forwarding stall; nulls lane 0 on the next cycle.
- ld_en_in  in  1  memory load writeback enable.
- m_ready  in  1  M-unit accepts an op this cycle.
- alu_op  out  LANES*OP_WIDTH  per-lane op to the ALUs; 0 = NOP.
- m_valid  out  1  M-unit request.
- m_op  out  OP_WIDTH  M-unit op.
- m_s1, m_s2  out  DATA_WIDTH  M-unit operands.
- m_lane  out  max(1,$clog2(LANES))  originating lane of the M-unit request.
- m_from_q  out  1  request is served from the queue, not the bypass path.
- ld_en_out  out  1  ld_en_in gated against a queued M-op writeback.
- issue_stall  out  1  hold the ID/EX bundle; do not advance.
- q_count  out  $clog2(DEPTH+1)  number of occupied queue entries.

Behaviour:
- Reset: queue empty, q_count=0, nop_ind=0. With inputs idle, all outputs are 0.
- nop_ind register: loads fwd_stall every cycle.
- Lane live: in_valid[i] & ~|lane_block[i-1:0] & ~(i==0 & nop_ind).
- M-op: lane is live and op >= MOP_BASE. All M-ops in a bundle are ordered by lane index.
- alu_op[i]: the lane op when live and not an M-op, else 0.
- Empty queue, m_ready=1:
  - Oldest M-op dispatches combinationally (zero latency): m_valid=1, m_from_q=0, m_lane=its lane.
  - Remaining M-ops enqueue at the clock edge.
- Non-empty queue:
  - Queue head drives m_valid=1, m_from_q=1.
  - Head pops when m_ready=1.
  - All incoming M-ops enqueue behind it; strict FIFO order is preserved.
- Empty queue, m_ready=0: all incoming M-ops enqueue.
- Capacity check:
  - need = incoming M-ops minus one bypass, if a bypass occurs.
  - free = DEPTH - q_count + pop.
  - If need > free: issue_stall=1, nothing enqueues, no bypass dispatch, alu_op is all 0 (whole bundle held).
  - A pop still occurs during a stall.
- Simultaneous push and pop in one cycle: q_count changes by pushes minus pops. A full queue with a pop accepts one push.
- ld_en_out = ld_en_in & ~(m_valid & m_from_q & m_ready).
- rst asserted mid-operation: queue flushed, queued ops discarded, no m_valid the following cycle.

Optional Feature:
- Macro MULDIV_ISSUE_PERF_EN.
- When defined, adds outputs perf_stall_cnt and perf_defer_cnt, each 32-bit, saturating at all-ones, cleared by rst:
  - perf_stall_cnt counts cycles with issue_stall=1.
  - perf_defer_cnt counts M-ops enqueued.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. LANES=2, MOP_BASE=16. Lane0 op=16 (s1=6, s2=7), lane1 op=3, m_ready=1, queue empty. Expect same cycle: m_valid=1, m_op=16, m_s1=6, m_lane=0, m_from_q=0, alu_op lane0=0, lane1=3.
2. Both lanes op=17, m_ready=1. Expect lane0 bypassed this cycle; q_count=1 next cycle; then m_from_q=1, m_lane=1, m_op=17.
3. DEPTH=2, m_ready=0, two consecutive bundles of 2 M-ops each. Expect first bundle enqueued (q_count=2); second bundle gets issue_stall=1 with alu_op=0. Raise m_ready: one pop, stall persists until free >= 2.
4. lane_block[0]=1, lane1 op=18. Expect alu_op lane1=0, no enqueue, m_valid tracks lane0 only.
5. fwd_stall=1 in cycle N, lane0 op=16 in cycle N+1. Expect lane0 nulled in N+1: no M dispatch, alu_op lane0=0.
6. Queue holds 1 entry, m_ready=1, ld_en_in=1. Expect ld_en_out=0 that cycle. Assert rst with the queue full: next cycle q_count=0 and m_valid=0.

Source files
------------

// File: rtl/muldiv_issue_arbiter_if.sv
// Issue-bundle and M-unit handshake bundle for muldiv_issue_arbiter.
// Lane fields are packed flat: lane i sits at [i*W +: W].
interface muldiv_issue_arbiter_if #(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5,
    parameter int DEPTH      = 2
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int QW = $clog2(DEPTH + 1);

    logic [LANES-1:0]            in_valid;
    logic [LANES*OP_WIDTH-1:0]   in_op;
    logic [LANES*DATA_WIDTH-1:0] in_s1;
    logic [LANES*DATA_WIDTH-1:0] in_s2;
    logic [LANES-1:0]            lane_block;
    logic                        fwd_stall;
    logic                        ld_en_in;
    logic                        m_ready;

    logic [LANES*OP_WIDTH-1:0]   alu_op;
    logic                        m_valid;
    logic [OP_WIDTH-1:0]         m_op;
    logic [DATA_WIDTH-1:0]       m_s1;
    logic [DATA_WIDTH-1:0]       m_s2;
    logic [LW-1:0]               m_lane;
    logic                        m_from_q;
    logic                        ld_en_out;
    logic                        issue_stall;
    logic [QW-1:0]               q_count;

    modport master (
        output in_valid, in_op, in_s1, in_s2, lane_block, fwd_stall, ld_en_in, m_ready,
        input  alu_op, m_valid, m_op, m_s1, m_s2, m_lane, m_from_q, ld_en_out,
               issue_stall, q_count
    );

    modport slave (
        input  in_valid, in_op, in_s1, in_s2, lane_block, fwd_stall, ld_en_in, m_ready,
        output alu_op, m_valid, m_op, m_s1, m_s2, m_lane, m_from_q, ld_en_out,
               issue_stall, q_count
    );
endinterface

// File: rtl/muldiv_issue_arbiter.sv
// Execute-stage issue steering: ALU ops per lane, M-ops in program order to one M-unit
// via a DEPTH-entry deferral queue. Optional perf counters under MULDIV_ISSUE_PERF_EN.
module muldiv_issue_arbiter #(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5,
    parameter int MOP_BASE   = 16,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    muldiv_issue_arbiter_if.slave bus
`ifdef MULDIV_ISSUE_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_defer_cnt
`endif
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int QW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [DATA_WIDTH-1:0] s1;
        logic [DATA_WIDTH-1:0] s2;
        logic [LW-1:0]         lane;
    } ment_t;

    ment_t          r_q [DEPTH];
    logic [QW-1:0]  r_count;
    logic           r_nop_ind;

    ment_t          w_ent [LANES];
    ment_t          w_q_nxt [DEPTH];
    ment_t          w_byp_ent;
    ment_t          w_m;
    logic [LANES-1:0] w_live;
    logic [LANES-1:0] w_is_m;
    logic           w_blk;
    logic           w_found;
    logic           w_q_empty;
    logic           w_pop;
    logic           w_byp_ok;
    logic           w_byp;
    logic           w_stall;
    int             w_first;
    int             w_n_m;
    int             w_need;
    int             w_free;
    int             w_pos;
    int             w_push;

    always_comb begin
        w_blk     = 1'b0;
        w_found   = 1'b0;
        w_first   = 0;
        w_n_m     = 0;
        w_byp_ent = '0;
        for (int i = 0; i < LANES; i++) begin
            w_ent[i].op   = bus.in_op[i*OP_WIDTH +: OP_WIDTH];
            w_ent[i].s1   = bus.in_s1[i*DATA_WIDTH +: DATA_WIDTH];
            w_ent[i].s2   = bus.in_s2[i*DATA_WIDTH +: DATA_WIDTH];
            w_ent[i].lane = LW'(i);
            // Any older blocking lane squashes this one; lane 0 also honours the
            // registered forwarding-stall null.
            w_live[i] = bus.in_valid[i] & ~w_blk & ~((i == 0) & r_nop_ind);
            w_blk     = w_blk | bus.lane_block[i];
            w_is_m[i] = w_live[i] & (w_ent[i].op >= OP_WIDTH'(MOP_BASE));
            if (w_is_m[i]) begin
                w_n_m = w_n_m + 1;
                if (!w_found) begin
                    w_found   = 1'b1;
                    w_first   = i;
                    w_byp_ent = w_ent[i];
                end
            end
        end

        w_q_empty = (r_count == '0);
        w_pop     = ~w_q_empty & bus.m_ready;
        w_byp_ok  = w_q_empty & bus.m_ready & w_found;
        w_need    = w_n_m - (w_byp_ok ? 1 : 0);
        w_free    = DEPTH - int'(r_count) + (w_pop ? 1 : 0);
        w_stall   = (w_need > w_free);
        w_byp     = w_byp_ok & ~w_stall;

        if (!w_q_empty)  w_m = r_q[0];
        else if (w_byp)  w_m = w_byp_ent;
        else             w_m = '0;

        bus.m_valid     = ~w_q_empty | w_byp;
        bus.m_from_q    = ~w_q_empty;
        bus.m_op        = w_m.op;
        bus.m_s1        = w_m.s1;
        bus.m_s2        = w_m.s2;
        bus.m_lane      = w_m.lane;
        bus.issue_stall = w_stall;
        bus.ld_en_out   = bus.ld_en_in & ~w_pop;
        bus.q_count     = r_count;

        bus.alu_op = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_live[i] && !w_is_m[i] && !w_stall)
                bus.alu_op[i*OP_WIDTH +: OP_WIDTH] = w_ent[i].op;
        end

        // Queue is kept head-at-slot-0: pop shifts down, pushes land after the survivors.
        for (int j = 0; j < DEPTH; j++) w_q_nxt[j] = r_q[j];
        if (w_pop) begin
            for (int j = 0; j < DEPTH - 1; j++) w_q_nxt[j] = r_q[j+1];
        end
        w_pos  = int'(r_count) - (w_pop ? 1 : 0);
        w_push = 0;
        for (int i = 0; i < LANES; i++) begin
            if (!w_stall && w_is_m[i] && !(w_byp && (i == w_first))) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (w_pos == j) w_q_nxt[j] = w_ent[i];
                end
                w_pos  = w_pos + 1;
                w_push = w_push + 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_nop_ind <= 1'b0;
        end else begin
            r_count   <= QW'(w_pos);
            r_nop_ind <= bus.fwd_stall;
        end
    end

    // Payload needs no reset: only slots below r_count are ever observed.
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) r_q[j] <= w_q_nxt[j];
    end

`ifdef MULDIV_ISSUE_PERF_EN
    logic [32:0] w_defer_sum;
    assign w_defer_sum = {1'b0, perf_defer_cnt} + 33'(w_push);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_defer_cnt <= '0;
        end else begin
            if (w_stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            perf_defer_cnt <= w_defer_sum[32] ? '1 : w_defer_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_muldiv_issue_arbiter.sv
// Randomized and directed check of muldiv_issue_arbiter against a queue-based model.
module tb_muldiv_issue_arbiter;
    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int OW    = 5;
    localparam int MB    = 16;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_issue_arbiter_if #(.LANES(LANES), .DATA_WIDTH(DW), .OP_WIDTH(OW), .DEPTH(DEPTH)) bus ();

`ifdef MULDIV_ISSUE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_defer_cnt;
`endif

    muldiv_issue_arbiter #(.LANES(LANES), .DATA_WIDTH(DW), .OP_WIDTH(OW), .MOP_BASE(MB), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef MULDIV_ISSUE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_defer_cnt (perf_defer_cnt)
`endif
    );

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        int            lane;
    } ent_t;

    ent_t mq[$];
    ent_t mops[$];
    logic m_nop;
    int   n_vec = 0;
    int   n_err = 0;

    // Model decisions for the current cycle, consumed at the next clock edge.
    bit   e_pop, e_byp, e_stall;
    logic [LANES*OW-1:0] e_alu;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit blk;
        int need, free;
        ent_t e, src;
        blk = 0;
        mops.delete();
        e_alu = '0;
        for (int i = 0; i < LANES; i++) begin
            e.op   = bus.in_op[i*OW +: OW];
            e.s1   = bus.in_s1[i*DW +: DW];
            e.s2   = bus.in_s2[i*DW +: DW];
            e.lane = i;
            if (bus.in_valid[i] && !blk && !(i == 0 && m_nop)) begin
                if (e.op >= MB) mops.push_back(e);
                else e_alu[i*OW +: OW] = e.op;
            end
            if (bus.lane_block[i]) blk = 1;
        end
        e_pop   = (mq.size() > 0) && bus.m_ready;
        e_byp   = (mq.size() == 0) && bus.m_ready && (mops.size() > 0);
        need    = mops.size() - (e_byp ? 1 : 0);
        free    = DEPTH - mq.size() + (e_pop ? 1 : 0);
        e_stall = need > free;
        if (e_stall) begin
            e_byp = 0;
            e_alu = '0;
        end
        src = '{op: '0, s1: '0, s2: '0, lane: 0};
        if (mq.size() > 0) src = mq[0];
        else if (e_byp)    src = mops[0];

        chk("alu_op",      bus.alu_op, e_alu);
        chk("m_valid",     bus.m_valid, (mq.size() > 0) || e_byp);
        chk("m_from_q",    bus.m_from_q, mq.size() > 0);
        chk("m_op",        bus.m_op, src.op);
        chk("m_s1",        bus.m_s1, src.s1);
        chk("m_s2",        bus.m_s2, src.s2);
        chk("m_lane",      bus.m_lane, src.lane);
        chk("issue_stall", bus.issue_stall, e_stall);
        chk("ld_en_out",   bus.ld_en_out, bus.ld_en_in && !e_pop);
        chk("q_count",     bus.q_count, mq.size());
    endtask

    task automatic model_clock();
        if (rst) begin
            mq.delete();
            m_nop = 0;
        end else begin
            m_nop = bus.fwd_stall;
            if (e_pop) void'(mq.pop_front());
            if (!e_stall)
                for (int k = (e_byp ? 1 : 0); k < mops.size(); k++) mq.push_back(mops[k]);
        end
    endtask

    task automatic eval();
        @(negedge clk);
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        bus.in_valid   = '0;
        bus.in_op      = '0;
        bus.in_s1      = '0;
        bus.in_s2      = '0;
        bus.lane_block = '0;
        bus.fwd_stall  = 1'b0;
        bus.ld_en_in   = 1'b0;
        bus.m_ready    = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [OW-1:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2);
        bus.in_valid[i]        = 1'b1;
        bus.in_op[i*OW +: OW]  = op;
        bus.in_s1[i*DW +: DW]  = s1;
        bus.in_s2[i*DW +: DW]  = s2;
    endtask

    initial begin
        m_nop = 0;
        idle();
        rst = 1'b1;
        @(posedge clk); model_clock(); #1;
        @(posedge clk); model_clock(); #1;
        rst = 1'b0;

        // Reset state with idle inputs
        eval();
        chk("rst_q_count", bus.q_count, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        adv();

        // Zero-latency bypass of lane 0, ALU op on lane 1
        idle(); bus.m_ready = 1;
        set_lane(0, 16, 6, 7); set_lane(1, 3, 0, 0);
        eval();
        chk("t1_m_valid", bus.m_valid, 1);
        chk("t1_m_op", bus.m_op, 16);
        chk("t1_m_s1", bus.m_s1, 6);
        chk("t1_m_lane", bus.m_lane, 0);
        chk("t1_from_q", bus.m_from_q, 0);
        chk("t1_alu", bus.alu_op, 10'd96);
        adv();

        // Two M-ops: lane 0 bypasses, lane 1 is deferred
        idle(); bus.m_ready = 1;
        set_lane(0, 17, 1, 1); set_lane(1, 17, 2, 2);
        eval();
        chk("t2_byp_lane", bus.m_lane, 0);
        adv();
        idle(); bus.m_ready = 1;
        eval();
        chk("t2_q_count", bus.q_count, 1);
        chk("t2_from_q", bus.m_from_q, 1);
        chk("t2_lane", bus.m_lane, 1);
        chk("t2_op", bus.m_op, 17);
        chk("t2_s1", bus.m_s1, 2);
        adv();

        // Fill the queue, then a stalled bundle until two slots free up
        idle();
        set_lane(0, 20, 10, 10); set_lane(1, 21, 11, 11);
        eval();
        chk("t3_no_stall", bus.issue_stall, 0);
        adv();
        eval();
        chk("t3_full", bus.q_count, 2);
        chk("t3_stall", bus.issue_stall, 1);
        chk("t3_alu0", bus.alu_op, 0);
        adv();
        bus.m_ready = 1; bus.ld_en_in = 1;
        eval();
        chk("t3_stall_pop", bus.issue_stall, 1);
        chk("t3_ld_gate", bus.ld_en_out, 0);
        adv();
        eval();
        chk("t3_q1", bus.q_count, 1);
        chk("t3_release", bus.issue_stall, 0);
        chk("t3_head_lane", bus.m_lane, 1);
        adv();
        idle();
        eval();
        chk("t3_refill", bus.q_count, 2);
        adv();

        // Reset flushes a full queue
        rst = 1;
        eval();
        adv();
        rst = 0;
        eval();
        chk("t6_rst_q", bus.q_count, 0);
        chk("t6_rst_mv", bus.m_valid, 0);
        adv();

        // One queued entry popping gates the load writeback
        idle(); set_lane(0, 16, 5, 5);
        eval();
        adv();
        idle(); bus.m_ready = 1; bus.ld_en_in = 1;
        eval();
        chk("t6_q1", bus.q_count, 1);
        chk("t6_ld_out", bus.ld_en_out, 0);
        adv();

        // Lane 0 blocks lane 1's M-op
        idle(); bus.m_ready = 1;
        set_lane(0, 4, 0, 0); set_lane(1, 18, 9, 9); bus.lane_block = 2'b01;
        eval();
        chk("t4_alu", bus.alu_op, 10'd4);
        chk("t4_mv", bus.m_valid, 0);
        adv();
        idle();
        eval();
        chk("t4_q", bus.q_count, 0);
        adv();

        // Forwarding stall nulls lane 0 the following cycle
        idle(); bus.fwd_stall = 1;
        eval();
        adv();
        idle(); bus.m_ready = 1; set_lane(0, 16, 3, 3);
        eval();
        chk("t5_mv", bus.m_valid, 0);
        chk("t5_alu", bus.alu_op, 0);
        adv();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            for (int i = 0; i < LANES; i++) begin
                if ($urandom_range(0, 3) != 0)
                    set_lane(i, OW'($urandom_range(0, 31)), $urandom, $urandom);
            end
            bus.lane_block = ($urandom_range(0, 5) == 0) ? LANES'($urandom) : '0;
            bus.fwd_stall  = ($urandom_range(0, 4) == 0);
            bus.ld_en_in   = $urandom_range(0, 1);
            bus.m_ready    = ($urandom_range(0, 2) != 0);
            rst            = ($urandom_range(0, 63) == 0);
            eval();
            adv();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
